// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame transmitter and the "1010" detector that consumes its stream.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SYNC = 2'b01,
        DATA = 2'b10
    } state_e;

    localparam int                  SYNC_LEN    = 4;
    localparam logic [SYNC_LEN-1:0] SYNC_PAT    = 4'b1010;
    localparam int                  FRAME_CNT_W = 8;

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Request/stream bundle between a frame requester and the serial transmitter.
interface serial_pattern_tx_if #(
    parameter int WIDTH = 8
);
    logic                                start;
    logic [WIDTH-1:0]                    i_data;
    logic                                ready;
    logic                                o_p;
    logic                                o_valid;
    logic                                o_last;
    logic [serial_pkg::FRAME_CNT_W-1:0]  frame_cnt;

    modport master (
        output start, i_data,
        input  ready, o_p, o_valid, o_last, frame_cnt
    );

    modport slave (
        input  start, i_data,
        output ready, o_p, o_valid, o_last, frame_cnt
    );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter: 4-bit sync preamble followed by a WIDTH-bit payload, MSB first.
// Outputs are decoded from state and registers only, so start/i_data never reach an output combinationally.
module serial_pattern_tx
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    serial_pattern_tx_if.slave   bus
);

    // One counter serves both phases, so it must hold the longer of the two.
    localparam int CNT_W = $clog2((WIDTH > SYNC_LEN) ? WIDTH : SYNC_LEN);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       shift_q, shift_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic ready_c, p_c, valid_c, last_c;

    // NOTE: every sequential register uses <= so all flops update from the same pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // NOTE: defaults first, so no path through the case leaves a variable unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        frame_cnt_d = frame_cnt_q;
        ready_c     = 1'b0;
        p_c         = 1'b0;
        valid_c     = 1'b0;
        last_c      = 1'b0;

        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.start) begin
                    shift_d = bus.i_data;
                    cnt_d   = CNT_W'(SYNC_LEN - 1);
                    state_d = SYNC;
                end
            end
            SYNC: begin
                valid_c = 1'b1;
                p_c     = SYNC_PAT[cnt_q[1:0]];
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(WIDTH - 1);
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                valid_c = 1'b1;
                p_c     = shift_q[WIDTH-1];
                shift_d = shift_q << 1;
                if (cnt_q == '0) begin
                    last_c      = 1'b1;
                    state_d     = IDLE;
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            // The spare encoding drops back to IDLE with every output held low.
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready     = ready_c;
    assign bus.o_p       = p_c;
    assign bus.o_valid   = valid_c;
    assign bus.o_last    = last_c;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: preamble/payload order, o_last, idle gap, abort, counter wrap, WIDTH=1.
module tb_serial_pattern_tx;
    import serial_pkg::*;

    logic clock = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_pass   = 0;

    serial_pattern_tx_if #(.WIDTH(8)) bus8 ();
    serial_pattern_tx_if #(.WIDTH(1)) bus1 ();

    serial_pattern_tx #(.WIDTH(8)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus8)
    );

    serial_pattern_tx #(.WIDTH(1)) u_dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Outputs are sampled 1 ns after the rising edge, well away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Walks the 12 valid cycles of the current 8-bit frame, then checks the idle cycle that follows.
    // A small "1010" detector model marks, per bit index, where the consumer would fire.
    task automatic check_frame(input string tag, input logic [11:0] exp_bits,
                               input logic [11:0] exp_hits, input logic [7:0] exp_cnt);
        logic [3:0]  hist = 4'b0000;
        logic [11:0] hits = '0;
        for (int i = 0; i < 12; i++) begin
            check($sformatf("%s valid[%0d]", tag, i), 32'(bus8.o_valid), 32'd1);
            check($sformatf("%s p[%0d]", tag, i), 32'(bus8.o_p), 32'(exp_bits[11-i]));
            check($sformatf("%s last[%0d]", tag, i), 32'(bus8.o_last), 32'(i == 11));
            check($sformatf("%s busy[%0d]", tag, i), 32'(bus8.ready), 32'd0);
            hist = {hist[2:0], bus8.o_p};
            if (hist == SYNC_PAT) hits[i] = 1'b1;
            tick();
        end
        check({tag, " gap ready"}, 32'(bus8.ready), 32'd1);
        check({tag, " gap valid"}, 32'(bus8.o_valid), 32'd0);
        check({tag, " gap last"}, 32'(bus8.o_last), 32'd0);
        check({tag, " frame_cnt"}, 32'(bus8.frame_cnt), 32'(exp_cnt));
        check({tag, " detector hits"}, 32'(hits), 32'(exp_hits));
    endtask

    initial begin
        reset       = 1'b0;
        bus8.start  = 1'b0;
        bus8.i_data = '0;
        bus1.start  = 1'b0;
        bus1.i_data = '0;

        repeat (2) tick();
        check("rst ready", 32'(bus8.ready), 32'd1);
        check("rst valid", 32'(bus8.o_valid), 32'd0);
        check("rst p", 32'(bus8.o_p), 32'd0);
        check("rst last", 32'(bus8.o_last), 32'd0);
        check("rst frame_cnt", 32'(bus8.frame_cnt), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("idle ready[%0d]", i), 32'(bus8.ready), 32'd1);
            check($sformatf("idle valid[%0d]", i), 32'(bus8.o_valid), 32'd0);
            check($sformatf("idle p[%0d]", i), 32'(bus8.o_p), 32'd0);
            check($sformatf("idle cnt[%0d]", i), 32'(bus8.frame_cnt), 32'd0);
        end

        // Abort during payload bit 3 of 8'h5A (bit value 1): outputs must clear at once.
        bus8.start  = 1'b1;
        bus8.i_data = 8'h5A;
        tick();
        bus8.start  = 1'b0;
        repeat (7) tick();
        check("abort pre valid", 32'(bus8.o_valid), 32'd1);
        check("abort pre p", 32'(bus8.o_p), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort valid", 32'(bus8.o_valid), 32'd0);
        check("abort p", 32'(bus8.o_p), 32'd0);
        check("abort last", 32'(bus8.o_last), 32'd0);
        check("abort ready", 32'(bus8.ready), 32'd1);
        check("abort frame_cnt", 32'(bus8.frame_cnt), 32'd0);
        #2 reset = 1'b1;
        repeat (2) tick();
        check("post-abort valid", 32'(bus8.o_valid), 32'd0);
        check("post-abort frame_cnt", 32'(bus8.frame_cnt), 32'd0);

        // Full frame of 8'hA5 after the abort.
        bus8.start  = 1'b1;
        bus8.i_data = 8'hA5;
        tick();
        bus8.start  = 1'b0;
        check_frame("A5", 12'b1010_1010_0101, 12'h0A8, 8'd1);

        // 8'h0A: detector fires after the preamble and after the trailing 1010.
        bus8.start  = 1'b1;
        bus8.i_data = 8'h0A;
        tick();
        bus8.start  = 1'b0;
        check_frame("0A", 12'b1010_0000_1010, 12'h808, 8'd2);

        // start held high over three frames; i_data moves mid-frame and must not disturb them.
        bus8.start  = 1'b1;
        bus8.i_data = 8'hFF;
        tick();
        bus8.i_data = 8'h00;
        check_frame("FF", 12'b1010_1111_1111, 12'h008, 8'd3);
        tick();
        bus8.i_data = 8'h3C;
        check_frame("00", 12'b1010_0000_0000, 12'h008, 8'd4);
        tick();
        bus8.i_data = 8'h81;
        bus8.start  = 1'b0;
        check_frame("3C", 12'b1010_0011_1100, 12'h008, 8'd5);

        // Bring the count to 255, then one more frame wraps it to 0.
        for (int k = 0; k < 250; k++) begin
            bus8.start = 1'b1;
            tick();
            bus8.start = 1'b0;
            repeat (12) tick();
        end
        check("wrap frame_cnt 255", 32'(bus8.frame_cnt), 32'd255);
        check("wrap ready", 32'(bus8.ready), 32'd1);
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        repeat (12) tick();
        check("wrap frame_cnt 0", 32'(bus8.frame_cnt), 32'd0);

        // WIDTH=1 instance: preamble plus a single payload bit.
        bus1.start  = 1'b1;
        bus1.i_data = 1'b1;
        tick();
        bus1.start  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            logic [4:0] w1_bits;
            w1_bits = 5'b10101;
            check($sformatf("w1 valid[%0d]", i), 32'(bus1.o_valid), 32'd1);
            check($sformatf("w1 p[%0d]", i), 32'(bus1.o_p), 32'(w1_bits[4-i]));
            check($sformatf("w1 last[%0d]", i), 32'(bus1.o_last), 32'(i == 4));
            tick();
        end
        check("w1 gap ready", 32'(bus1.ready), 32'd1);
        check("w1 gap valid", 32'(bus1.o_valid), 32'd0);
        check("w1 frame_cnt", 32'(bus1.frame_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
